// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_pkg
//  Description : Shared definitions for the key debouncer: per-channel FSM
//                state encoding and the default debounce interval
//                (20 ms at 50 MHz).
//  Revision    : 1.0 - initial release
// ============================================================================
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_REL   = 2'd0,    // released, idle
        ST_CHK_P = 2'd1,    // qualifying a press
        ST_PRS   = 2'd2,    // pressed, idle
        ST_CHK_R = 2'd3     // qualifying a release
    } key_state_t;

    localparam int DEB_CNT_DEFAULT = 1_000_000;

endpackage : key_debounce_pkg
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_ch
//  Description : One key channel: 2-flop synchroniser, stability counter and
//                4-state debounce FSM. Produces a registered active-high
//                level and one-cycle press (and optionally release) pulses.
//  Ports       : clk         - system clock
//                rst_n       - asynchronous active-low reset
//                key_n       - raw key, active-low, asynchronous
//                key_level   - debounced level, 1 = pressed
//                key_press   - one-cycle pulse on accepted press
//                key_release - one-cycle pulse on accepted release
//                              (present only with KEY_RELEASE_PULSE_EN)
//  Config      : KEY_RELEASE_PULSE_EN - enables the release pulse output
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press
`ifdef KEY_RELEASE_PULSE_EN
    ,
    output logic key_release
`endif
);

    localparam int                 c_cnt_w    = $clog2(DEB_CNT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CNT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               w_key_sync;
    key_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;

    // Flops reset to 1 so a released key reads as released from reset on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_sync = ~r_sync2;

    // The counter is cleared on every exit from a CHK state, so it never
    // needs to count past DEB_CNT-1 and cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_REL;
            r_cnt       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
            key_release <= 1'b0;
`endif
        end else begin
            key_press   <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
            key_release <= 1'b0;
`endif
            case (r_state)
                ST_REL: begin
                    if (w_key_sync) begin
                        r_state <= ST_CHK_P;
                        r_cnt   <= c_cnt_one;
                    end
                end
                ST_CHK_P: begin
                    if (!w_key_sync) begin
                        r_state <= ST_REL;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state   <= ST_PRS;
                        r_cnt     <= '0;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_PRS: begin
                    if (!w_key_sync) begin
                        r_state <= ST_CHK_R;
                        r_cnt   <= c_cnt_one;
                    end
                end
                ST_CHK_R: begin
                    if (w_key_sync) begin
                        r_state <= ST_PRS;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state   <= ST_REL;
                        r_cnt     <= '0;
                        key_level <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
                        key_release <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= ST_REL;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule : key_debounce_ch
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Multi-channel push-button synchroniser and debouncer.
//                Each active-low asynchronous key is synchronised and
//                filtered independently into a clean active-high level plus
//                one-cycle press (and optionally release) pulses.
//  Ports       : clk         - system clock
//                rst_n       - asynchronous active-low reset
//                key_n       - [KEY_NUM] raw keys, active-low
//                key_level   - [KEY_NUM] debounced levels, 1 = pressed
//                key_press   - [KEY_NUM] press pulses
//                key_release - [KEY_NUM] release pulses
//                              (present only with KEY_RELEASE_PULSE_EN)
//  Config      : KEY_RELEASE_PULSE_EN - enables the release pulse outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int KEY_NUM = 2,
    parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_n,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press
`ifdef KEY_RELEASE_PULSE_EN
    ,
    output logic [KEY_NUM-1:0] key_release
`endif
);

    for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_ch
        key_debounce_ch #(
            .DEB_CNT (DEB_CNT)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_n       (key_n[gi]),
            .key_level   (key_level[gi]),
            .key_press   (key_press[gi])
`ifdef KEY_RELEASE_PULSE_EN
            ,
            .key_release (key_release[gi])
`endif
        );
    end

endmodule : key_debounce
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce
//  Description : Self-checking bench for key_debounce (KEY_NUM=2, DEB_CNT=4).
//                A run-length reference model tracks every cycle; directed
//                sequences, a vector table and random stimulus drive it.
//  Config      : KEY_RELEASE_PULSE_EN - also checks release pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    localparam int KN  = 2;
    localparam int DEB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KN-1:0] key_n = '1;
    logic [KN-1:0] key_level;
    logic [KN-1:0] key_press;
`ifdef KEY_RELEASE_PULSE_EN
    logic [KN-1:0] key_release;
`endif

    key_debounce #(.KEY_NUM(KN), .DEB_CNT(DEB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press)
`ifdef KEY_RELEASE_PULSE_EN
        ,
        .key_release (key_release)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int edges = 0;
    int p_acc [KN];
    int r_acc [KN];

    // Reference model: two-sample delay line, then a per-channel run
    // length of samples disagreeing with the accepted level.
    logic [KN-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel;
    int            m_run [KN];

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1; m_lvl = '0; m_prs = '0; m_rel = '0;
        for (int i = 0; i < KN; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        logic [KN-1:0] ks;
        if (!rst_n) begin
            model_reset();
        end else begin
            ks = ~m_s2;
            m_s2 = m_s1;
            m_s1 = key_n;
            m_prs = '0; m_rel = '0;
            for (int i = 0; i < KN; i++) begin
                if (ks[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_lvl[i] = ks[i];
                        m_run[i] = 0;
                        if (ks[i]) m_prs[i] = 1'b1;
                        else       m_rel[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [KN-1:0] act, input logic [KN-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic clear_acc();
        for (int i = 0; i < KN; i++) begin p_acc[i] = 0; r_acc[i] = 0; end
    endtask

    // One clock: model steps on the rising edge, outputs checked on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        edges++;
        @(negedge clk);
        check("model_level", key_level, m_lvl);
        check("model_press", key_press, m_prs);
`ifdef KEY_RELEASE_PULSE_EN
        check("model_release", key_release, m_rel);
        check("press_and_release", key_press & key_release, '0);
        for (int i = 0; i < KN; i++) r_acc[i] += int'(key_release[i]);
`endif
        for (int i = 0; i < KN; i++) p_acc[i] += int'(key_press[i]);
    endtask

    // Asynchronous reset assertion between clock edges.
    task automatic async_reset(input string name);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({name, "_level"}, key_level, '0);
        check({name, "_press"}, key_press, '0);
`ifdef KEY_RELEASE_PULSE_EN
        check({name, "_release"}, key_release, '0);
`endif
    endtask

    // Edges until key_level reaches target; -1 if it never does.
    task automatic measure(input logic [KN-1:0] target, output int at);
        int e0;
        e0 = edges;
        at = -1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (at < 0 && key_level == target) at = edges - e0;
        end
    endtask

    typedef struct {
        logic [KN-1:0] kn;
        int            hold;
        logic [KN-1:0] lvl;
        logic [KN-1:0] prs;
        logic [KN-1:0] rel;
    } vec_t;

    vec_t tbl [10];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int at;
        model_reset();
        clear_acc();

        tbl[0] = '{2'b11, 10, 2'b00, 2'b00, 2'b11};  // release both
        tbl[1] = '{2'b10, 10, 2'b01, 2'b01, 2'b00};  // clean press ch0
        tbl[2] = '{2'b11,  3, 2'b01, 2'b00, 2'b00};  // 3-cycle high glitch while pressed
        tbl[3] = '{2'b10, 10, 2'b01, 2'b00, 2'b00};
        tbl[4] = '{2'b00, 10, 2'b11, 2'b10, 2'b00};  // press ch1
        tbl[5] = '{2'b01,  2, 2'b11, 2'b00, 2'b00};  // short glitch ch0
        tbl[6] = '{2'b00, 10, 2'b11, 2'b00, 2'b00};
        tbl[7] = '{2'b11, 10, 2'b00, 2'b00, 2'b11};  // simultaneous release
        tbl[8] = '{2'b01,  3, 2'b00, 2'b00, 2'b00};  // 3-cycle low glitch ch1
        tbl[9] = '{2'b11, 10, 2'b00, 2'b00, 2'b00};

        // Reset with both keys held: outputs 0 at once, then 6-edge qualification.
        key_n = 2'b00;
        #1;
        check("reset_level", key_level, '0);
        check("reset_press", key_press, '0);
        cyc(); cyc();
        rst_n = 1'b1;
        clear_acc();
        measure(2'b11, at);
        check_int("reset_hold_latency", at, 6);
        check_int("reset_hold_press0", p_acc[0], 1);
        check_int("reset_hold_press1", p_acc[1], 1);

        // Vector table.
        for (int r = 0; r < 10; r++) begin
            clear_acc();
            key_n = tbl[r].kn;
            repeat (tbl[r].hold) cyc();
            check($sformatf("tbl%0d_level", r), key_level, tbl[r].lvl);
            for (int i = 0; i < KN; i++) begin
                check_int($sformatf("tbl%0d_press%0d", r, i), p_acc[i], int'(tbl[r].prs[i]));
`ifdef KEY_RELEASE_PULSE_EN
                check_int($sformatf("tbl%0d_release%0d", r, i), r_acc[i], int'(tbl[r].rel[i]));
`endif
            end
        end

        // Bounce on ch0, then a steady press 6 edges after the final fall.
        clear_acc();
        for (int b = 0; b < 2; b++) begin
            key_n = 2'b10; cyc(); cyc();
            key_n = 2'b11; cyc(); cyc();
        end
        key_n = 2'b10;
        begin
            int e0;
            e0 = edges;
            at = -1;
            for (int k = 0; k < 12; k++) begin
                cyc();
                if (at < 0 && key_press[0]) at = edges - e0;
            end
        end
        check_int("bounce_press_edge", at, 6);
        check_int("bounce_press_count", p_acc[0], 1);
        check_int("bounce_ch1_quiet", p_acc[1], 0);
        key_n = 2'b11;
        repeat (10) cyc();

        // Reset two cycles into press qualification, then re-qualify.
        key_n = 2'b10;
        repeat (4) cyc();
        async_reset("midchk_reset");
        cyc(); cyc();
        rst_n = 1'b1;
        clear_acc();
        measure(2'b01, at);
        check_int("midchk_requalify_latency", at, 6);
        check_int("midchk_press_count", p_acc[0], 1);

        // Reset while pressed clears the level immediately.
        async_reset("pressed_reset");
        key_n = 2'b11;
        cyc(); cyc();
        rst_n = 1'b1;
        repeat (6) cyc();

        // Random stimulus with occasional asynchronous resets.
        for (int it = 0; it < 60; it++) begin
            key_n = KN'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) begin
                async_reset("rand_reset");
                cyc();
                rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 8)) cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_key_debounce
`default_nettype wire
